fft2d_corner_turn: RTL and testbench
====================================

Name: fft2d_corner_turn

Overview:
- Parametrised, double-buffered (ping-pong) corner-turn memory between the row-FFT and column-FFT cores of the 2D FFT datapath.
- Accepts one N×N complex frame in row-major order on an AXI-Stream slave.
- Replays the frame on an AXI-Stream master, column-major (transpose mode) or row-major (bypass mode), with per-column tlast.
- Full backpressure on both sides; one frame can be written while the previous one is read.

Parameters:
N_LOG2, 7, log2 of matrix side N (N = 128 default); legal range 2..9
DATA_W, 16, width of each real/imag component; tdata = 2*DATA_W

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
transpose  in  1  1 = column-major readout, 0 = row-major bypass
s_axis_data_tdata  in  2*DATA_W  [2*DATA_W-1:DATA_W] imag, [DATA_W-1:0] real
s_axis_data_tvalid  in  1  input sample valid
s_axis_data_tready  out  1  input accept
s_axis_data_tlast  in  1  end of row, expected on every N-th sample
m_axis_data_tdata  out  2*DATA_W  output sample, same packing
m_axis_data_tvalid  out  1  output valid
m_axis_data_tready  in  1  downstream accept
m_axis_data_tlast  out  1  last sample of each output line (every N samples)
m_frame_last  out  1  last sample of the whole N×N frame
event_tlast_unexpected  out  1  one-cycle pulse: s_tlast high on a non-row-end sample
event_tlast_missing  out  1  one-cycle pulse: s_tlast low on a row-end sample
busy  out  1  high when either bank holds data or a read is in flight

Behaviour:
- Reset: all outputs 0, except s_axis_data_tready = 1 one cycle after rst deasserts. Both banks empty; wr_bank = rd_bank = 0; all counters 0. rst mid-frame discards all buffered data with no partial output.
- Write side:
  - A sample is accepted when tvalid & tready.
  - It is stored at bank wr_bank, address row*N + col. col wraps at N-1 and increments row; the last accept marks the bank full when row = col = N-1.
  - The bank then toggles.
  - s_tready = 0 while the target bank is full (reader not finished).
- tlast checks:
  - Checked on every accept. A mismatch pulses the matching event for one cycle, the cycle after the accept.
  - The sample is still stored and the counters are not resynchronised.
- Read side FSM:
  - IDLE -> (bank rd_bank full) -> PRIME: latch transpose, issue first RAM read.
  - PRIME -> STREAM: tvalid asserted 2 cycles after the bank-full edge.
  - STREAM: address col*N + row when transposed, else row*N + col. The inner index advances on each handshake.
  - 1-cycle synchronous RAM latency is hidden by a 2-entry output skid. With tready held high the output rate is 1 sample/clk, with no bubbles inside a frame.
  - tvalid is held, and tdata is stable, while tready is low.
  - m_tlast is set when the inner index = N-1. m_frame_last is set on sample N*N-1.
  - After the final handshake: mark the bank empty, toggle rd_bank, go to IDLE. If the other bank is already full, go directly to PRIME (one bubble cycle allowed between frames).
- Simultaneous events:
  - Writer filling bank A on the same edge the reader frees bank B: both take effect.
  - s_tready stays 1 with no stall cycle.
- transpose changes mid-frame are ignored until the next PRIME.
- busy = bank0_full | bank1_full | (state != IDLE).

Decomposition:
- Package fft2d_pkg:
  - N_LOG2/DATA_W defaults
  - read FSM state enum (IDLE, PRIME, STREAM)
  - complex sample struct {imag, real}
- Sub-module fft2d_tp_ram: simple dual-port RAM with depth 2*N*N, width 2*DATA_W, one write port, one read port, 1-cycle read latency. Bank select is the address MSB.
- Top handles the counters, FSM, skid buffer and tlast checks.

Test Plan:
- Transpose, 4×4 (N_LOG2=2): input tdata = 0..15 row-major with correct tlast, m_tready=1 -> output 0,4,8,12,1,5,…,15. m_tlast on the 4th/8th/12th/16th sample; m_frame_last only on 15. First tvalid 2 clk after the 16th accept.
- Bypass, transpose=0: same input -> output 0..15 in order.
- Back-to-back frames, 3 frames with m_tready random 50%: every output frame equals the transpose of its input. s_tready drops only when both banks are full; no sample lost or duplicated (scoreboard).
- tlast error: frame with tlast on sample 2 and missing on sample 3 -> event_tlast_unexpected pulses once and event_tlast_missing pulses once. Output data remains the correct transpose.
- Backpressure hold: m_tready low for 5 cycles mid-column -> tdata and tvalid stable, next sample is correct after release.
- Reset mid-operation: rst for 1 clk after 9 accepts -> tvalid = 0 and busy = 0. The next full frame 0..15 transposes correctly with no stale data.

Source files
------------

// File: rtl/fft2d_pkg.sv
// Shared types and defaults for the 2D-FFT corner-turn buffer.
package fft2d_pkg;

    localparam int N_LOG2_DEF = 7;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } rd_state_e;

    // 're' stands for the real part ('real' is a reserved word)
    typedef struct packed {
        logic [DATA_W_DEF-1:0] imag;
        logic [DATA_W_DEF-1:0] re;
    } cplx_t;

endpackage

// File: rtl/fft2d_corner_turn_if.sv
// AXI-Stream style sample channel used on both sides of the corner turn.
interface fft2d_corner_turn_if #(
    parameter int DATA_W = 16
);
    logic [2*DATA_W-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft2d_tp_ram.sv
// Simple dual-port RAM, one write and one read port, registered read data.
module fft2d_tp_ram #(
    parameter int ADDR_W = 15,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/fft2d_corner_turn.sv
// Ping-pong corner-turn buffer: row-major frames in, column-major (or row-major) frames out.
module fft2d_corner_turn
    import fft2d_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       transpose,
    fft2d_corner_turn_if.slave         s_axis_data,
    fft2d_corner_turn_if.master        m_axis_data,
    output logic                       m_frame_last,
    output logic                       event_tlast_unexpected,
    output logic                       event_tlast_missing,
    output logic                       busy
);
    localparam int AW = 2 * N_LOG2 + 1;
    localparam int W  = 2 * DATA_W;
    localparam logic [N_LOG2-1:0] IDX_MAX = {N_LOG2{1'b1}};
    localparam logic [N_LOG2-1:0] IDX_ONE = {{(N_LOG2-1){1'b0}}, 1'b1};

    // write side
    logic              wr_bank_r;
    logic [N_LOG2-1:0] wr_row_r;
    logic [N_LOG2-1:0] wr_col_r;
    logic [1:0]        bank_full_r;
    logic              tready_r;
    logic              ev_unexp_r;
    logic              ev_miss_r;
    logic              wr_acc_s;
    logic              row_end_s;
    logic              wr_fill_s;
    logic [1:0]        bank_full_nxt_s;
    logic              wr_bank_nxt_s;

    // read side
    rd_state_e         state_r;
    logic              rd_bank_r;
    logic              tp_r;
    logic [N_LOG2-1:0] iss_inner_r;
    logic [N_LOG2-1:0] iss_outer_r;
    logic              iss_done_r;
    logic              pend_r;
    logic              pend_tlast_r;
    logic              pend_flast_r;
    logic              out_valid_r;
    logic [W-1:0]      out_data_r;
    logic              out_tlast_r;
    logic              out_flast_r;
    logic              sk_valid_r;
    logic [W-1:0]      sk_data_r;
    logic              sk_tlast_r;
    logic              sk_flast_r;
    logic [W-1:0]      rdata_s;
    logic              pop_s;
    logic              rd_done_s;
    logic              start_idle_s;
    logic              chain_s;
    logic              first_iss_s;
    logic [1:0]        occ_s;
    logic              room_s;
    logic              rd_en_s;
    logic              rd_bank_sel_s;
    logic [N_LOG2-1:0] iss_in_s;
    logic [N_LOG2-1:0] iss_out_s;
    logic              iss_tlast_s;
    logic              iss_flast_s;
    logic [AW-1:0]     rd_addr_s;

    assign wr_acc_s  = s_axis_data.tvalid & tready_r;
    assign row_end_s = (wr_col_r == IDX_MAX);
    assign wr_fill_s = wr_acc_s & row_end_s & (wr_row_r == IDX_MAX);

    assign pop_s     = out_valid_r & m_axis_data.tready;
    assign rd_done_s = pop_s & out_flast_r & (state_r == STREAM);

    // Writer and reader never touch the same bank, so set and clear can coincide safely
    assign bank_full_nxt_s[0] = (bank_full_r[0] | (wr_fill_s & ~wr_bank_r)) & ~(rd_done_s & ~rd_bank_r);
    assign bank_full_nxt_s[1] = (bank_full_r[1] | (wr_fill_s &  wr_bank_r)) & ~(rd_done_s &  rd_bank_r);
    assign wr_bank_nxt_s      = wr_bank_r ^ wr_fill_s;

    // Write counters, bank occupancy, input ready and tlast checks
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r   <= 1'b0;
            wr_row_r    <= '0;
            wr_col_r    <= '0;
            bank_full_r <= 2'b00;
            tready_r    <= 1'b0;
            ev_unexp_r  <= 1'b0;
            ev_miss_r   <= 1'b0;
        end else begin
            tready_r    <= ~bank_full_nxt_s[wr_bank_nxt_s];
            bank_full_r <= bank_full_nxt_s;
            wr_bank_r   <= wr_bank_nxt_s;
            ev_unexp_r  <= wr_acc_s &  s_axis_data.tlast & ~row_end_s;
            ev_miss_r   <= wr_acc_s & ~s_axis_data.tlast &  row_end_s;
            if (wr_acc_s) begin
                wr_col_r <= wr_col_r + IDX_ONE;
                if (row_end_s) begin
                    wr_row_r <= wr_row_r + IDX_ONE;
                end
            end
        end
    end

    // The first read of a frame is issued while entering PRIME, hiding the RAM latency
    assign start_idle_s  = (state_r == IDLE) & bank_full_r[rd_bank_r];
    assign chain_s       = rd_done_s & bank_full_r[~rd_bank_r];
    assign first_iss_s   = start_idle_s | chain_s;
    assign occ_s         = {1'b0, out_valid_r} + {1'b0, sk_valid_r} + {1'b0, pend_r};
    assign room_s        = (occ_s < 2'd2) | ((occ_s == 2'd2) & pop_s);
    assign rd_en_s       = first_iss_s | ((state_r != IDLE) & ~iss_done_r & room_s);
    assign rd_bank_sel_s = chain_s ? ~rd_bank_r : rd_bank_r;
    assign iss_in_s      = first_iss_s ? {N_LOG2{1'b0}} : iss_inner_r;
    assign iss_out_s     = first_iss_s ? {N_LOG2{1'b0}} : iss_outer_r;
    assign iss_tlast_s   = (iss_in_s == IDX_MAX);
    assign iss_flast_s   = iss_tlast_s & (iss_out_s == IDX_MAX);
    assign rd_addr_s     = tp_r ? {rd_bank_sel_s, iss_in_s, iss_out_s}
                                : {rd_bank_sel_s, iss_out_s, iss_in_s};

    fft2d_tp_ram #(
        .ADDR_W (AW),
        .WIDTH  (W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr ({wr_bank_r, wr_row_r, wr_col_r}),
        .wdata (s_axis_data.tdata),
        .re    (rd_en_s),
        .raddr (rd_addr_s),
        .rdata (rdata_s)
    );

    // Read FSM, read issue counters and 2-entry output skid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rd_bank_r    <= 1'b0;
            tp_r         <= 1'b0;
            iss_inner_r  <= '0;
            iss_outer_r  <= '0;
            iss_done_r   <= 1'b0;
            pend_r       <= 1'b0;
            pend_tlast_r <= 1'b0;
            pend_flast_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_tlast_r  <= 1'b0;
            out_flast_r  <= 1'b0;
            sk_valid_r   <= 1'b0;
            sk_data_r    <= '0;
            sk_tlast_r   <= 1'b0;
            sk_flast_r   <= 1'b0;
        end else begin
            pend_r       <= rd_en_s;
            pend_tlast_r <= iss_tlast_s;
            pend_flast_r <= iss_flast_s;
            if (rd_en_s) begin
                iss_inner_r <= iss_in_s + IDX_ONE;
                iss_outer_r <= iss_tlast_s ? (iss_out_s + IDX_ONE) : iss_out_s;
                iss_done_r  <= iss_flast_s;
            end

            if (~out_valid_r | pop_s) begin
                if (sk_valid_r) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= sk_data_r;
                    out_tlast_r <= sk_tlast_r;
                    out_flast_r <= sk_flast_r;
                    sk_valid_r  <= pend_r;
                    sk_data_r   <= rdata_s;
                    sk_tlast_r  <= pend_tlast_r;
                    sk_flast_r  <= pend_flast_r;
                end else begin
                    out_valid_r <= pend_r;
                    out_data_r  <= pend_r ? rdata_s : out_data_r;
                    out_tlast_r <= pend_r & pend_tlast_r;
                    out_flast_r <= pend_r & pend_flast_r;
                    sk_valid_r  <= 1'b0;
                end
            end else if (pend_r) begin
                sk_valid_r <= 1'b1;
                sk_data_r  <= rdata_s;
                sk_tlast_r <= pend_tlast_r;
                sk_flast_r <= pend_flast_r;
            end

            case (state_r)
                IDLE: begin
                    if (start_idle_s) begin
                        state_r <= PRIME;
                        tp_r    <= transpose;
                    end
                end
                PRIME: begin
                    state_r <= STREAM;
                end
                STREAM: begin
                    if (rd_done_s) begin
                        rd_bank_r <= ~rd_bank_r;
                        if (chain_s) begin
                            state_r <= PRIME;
                            tp_r    <= transpose;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_data.tready     = tready_r;
    assign m_axis_data.tvalid     = out_valid_r;
    assign m_axis_data.tdata      = out_data_r;
    assign m_axis_data.tlast      = out_tlast_r;
    assign m_frame_last           = out_flast_r;
    assign event_tlast_unexpected = ev_unexp_r;
    assign event_tlast_missing    = ev_miss_r;
    assign busy                   = bank_full_r[0] | bank_full_r[1] | (state_r != IDLE);
endmodule

// File: tb/tb_fft2d_corner_turn.sv
// Self-checking bench: 4x4 corner turn against a queue-based frame model.
module tb_fft2d_corner_turn;
    import fft2d_pkg::*;

    localparam int NS = 4;
    localparam int NN = NS * NS;

    typedef struct {
        logic [31:0] d;
        logic        tl;
        logic        fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic transpose = 1'b1;
    logic rst_seen = 1'b1;
    logic m_frame_last, event_tlast_unexpected, event_tlast_missing, busy;

    fft2d_corner_turn_if #(.DATA_W(16)) s_if ();
    fft2d_corner_turn_if #(.DATA_W(16)) m_if ();

    fft2d_corner_turn #(.N_LOG2(2), .DATA_W(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .transpose              (transpose),
        .s_axis_data            (s_if),
        .m_axis_data            (m_if),
        .m_frame_last           (m_frame_last),
        .event_tlast_unexpected (event_tlast_unexpected),
        .event_tlast_missing    (event_tlast_missing),
        .busy                   (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    exp_t exp_q[$];
    logic [31:0] in_buf [NN];
    int in_cnt = 0;
    int outstanding = 0;
    int lat_cnt = 0;
    int pop_cnt = 0;
    int n_unexp = 0;
    int n_miss = 0;
    int rdy_mode = 0;
    logic tp_model = 1'b1;
    logic exp_unexp = 1'b0;
    logic exp_miss = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_pop_nonlast = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic prev_tl = 1'b0;
    logic [31:0] out_log[$];
    logic [15:0] tl_mask = 16'd0;
    logic [15:0] fl_mask = 16'd0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) rst_seen <= rst;

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Monitor and model: compares every cycle at the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            chk1("rst_m_tvalid", m_if.tvalid, 1'b0);
            chk1("rst_m_tlast", m_if.tlast, 1'b0);
            chk1("rst_frame_last", m_frame_last, 1'b0);
            chk1("rst_s_tready", s_if.tready, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_ev_unexp", event_tlast_unexpected, 1'b0);
            chk1("rst_ev_miss", event_tlast_missing, 1'b0);
            exp_q.delete();
            in_cnt = 0; outstanding = 0; lat_cnt = 0;
            exp_unexp = 1'b0; exp_miss = 1'b0;
            prev_stall = 1'b0; prev_pop_nonlast = 1'b0;
        end else begin
            chk1("ev_unexpected", event_tlast_unexpected, exp_unexp);
            chk1("ev_missing", event_tlast_missing, exp_miss);
            if (event_tlast_unexpected) n_unexp++;
            if (event_tlast_missing) n_miss++;
            chk1("s_tready", s_if.tready, outstanding < 2);
            chk1("busy", busy, outstanding > 0);
            if (exp_q.size() == 0) chk1("idle_tvalid", m_if.tvalid, 1'b0);
            if (prev_stall) begin
                chk1("hold_tvalid", m_if.tvalid, 1'b1);
                chk32("hold_tdata", m_if.tdata, prev_data);
                chk1("hold_tlast", m_if.tlast, prev_tl);
            end
            if (prev_pop_nonlast) chk1("no_bubble", m_if.tvalid, 1'b1);
            if (lat_cnt == 1 || lat_cnt == 2) begin
                chk1("first_valid_early", m_if.tvalid, 1'b0);
                lat_cnt++;
            end else if (lat_cnt == 3) begin
                chk1("first_valid_latency", m_if.tvalid, 1'b1);
                lat_cnt = 0;
            end
            prev_pop_nonlast = 1'b0;
            if (m_if.tvalid && m_if.tready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    chk1("spurious_output", m_if.tvalid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk32("out_tdata", m_if.tdata, e.d);
                    chk1("out_tlast", m_if.tlast, e.tl);
                    chk1("out_frame_last", m_frame_last, e.fl);
                    if (e.fl) outstanding--;
                    prev_pop_nonlast = !e.fl;
                end
                if (out_log.size() < 16) begin
                    tl_mask[out_log.size()] = m_if.tlast;
                    fl_mask[out_log.size()] = m_frame_last;
                end
                out_log.push_back(m_if.tdata);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data = m_if.tdata;
            prev_tl = m_if.tlast;

            exp_unexp = 1'b0;
            exp_miss = 1'b0;
            if (!rst && s_if.tvalid && s_if.tready) begin
                exp_unexp = s_if.tlast && (in_cnt % NS != NS - 1);
                exp_miss = !s_if.tlast && (in_cnt % NS == NS - 1);
                in_buf[in_cnt] = s_if.tdata;
                in_cnt++;
                if (in_cnt == NN) begin
                    for (int k = 0; k < NN; k++) begin
                        e.d = tp_model ? in_buf[(k % NS) * NS + k / NS] : in_buf[k];
                        e.tl = (k % NS == NS - 1);
                        e.fl = (k == NN - 1);
                        exp_q.push_back(e);
                    end
                    if (outstanding == 0) lat_cnt = 1;
                    outstanding++;
                    in_cnt = 0;
                end
            end
        end
    end

    // Downstream ready generator
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_if.tready = 1'b1;
            else if (rdy_mode == 1) m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_one(input logic [31:0] d, input logic tl);
        int t = 0;
        s_if.tdata = d;
        s_if.tlast = tl;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk1("s_accept_timeout", t < 2000, 1'b1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit rnd, input bit bad_tlast, input int count);
        cplx_t c;
        logic tl;
        for (int i = 0; i < count; i++) begin
            c.re = 16'(i);
            c.imag = 16'd0;
            tl = (i % NS == NS - 1);
            if (bad_tlast && i == 2) tl = 1'b1;
            if (bad_tlast && i == 3) tl = 1'b0;
            send_one(rnd ? $urandom : c, tl);
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk1("drain_timeout", t < 3000, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_log.delete();
        tl_mask = 16'd0;
        fl_mask = 16'd0;
    endtask

    initial begin
        int base;
        int t;
        s_if.tvalid = 1'b0;
        s_if.tdata = 32'd0;
        s_if.tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // transpose, counting data
        clear_logs();
        send_frame(1'b0, 1'b0, NN);
        drain();
        chk32("t1_count", 32'(out_log.size()), 32'd16);
        chk32("t1_out1", out_log[1], 32'd4);
        chk32("t1_out3", out_log[3], 32'd12);
        chk32("t1_out4", out_log[4], 32'd1);
        chk32("t1_out15", out_log[15], 32'd15);
        chk32("t1_tlast_mask", 32'(tl_mask), 32'h8888);
        chk32("t1_flast_mask", 32'(fl_mask), 32'h8000);

        // bypass
        transpose = 1'b0;
        tp_model = 1'b0;
        clear_logs();
        send_frame(1'b0, 1'b0, NN);
        drain();
        chk32("t2_out1", out_log[1], 32'd1);
        chk32("t2_out4", out_log[4], 32'd4);
        chk32("t2_out14", out_log[14], 32'd14);

        // back-to-back random frames, random downstream ready
        transpose = 1'b1;
        tp_model = 1'b1;
        rdy_mode = 1;
        base = pop_cnt;
        for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0, NN);
        drain();
        rdy_mode = 0;
        chk32("t3_pops", 32'(pop_cnt - base), 32'd48);

        // tlast errors
        n_unexp = 0;
        n_miss = 0;
        send_frame(1'b1, 1'b1, NN);
        drain();
        chk32("t4_unexp_pulses", 32'(n_unexp), 32'd1);
        chk32("t4_miss_pulses", 32'(n_miss), 32'd1);

        // backpressure hold mid-column, with a transpose toggle that must be ignored
        rdy_mode = 2;
        clear_logs();
        base = pop_cnt;
        send_frame(1'b0, 1'b0, NN);
        t = 0;
        while (pop_cnt < base + 6 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        m_if.tready = 1'b0;
        transpose = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        m_if.tready = 1'b1;
        drain();
        transpose = 1'b1;
        chk32("t5_out7", out_log[7], 32'd13);
        chk32("t5_out8", out_log[8], 32'd2);

        // reset with one frame buffered and 9 samples of the next written
        m_if.tready = 1'b0;
        send_frame(1'b1, 1'b0, NN);
        send_frame(1'b0, 1'b0, 9);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        m_if.tready = 1'b1;
        @(negedge clk);
        chk1("t6_tvalid_after_rst", m_if.tvalid, 1'b0);
        chk1("t6_busy_after_rst", busy, 1'b0);
        clear_logs();
        send_frame(1'b0, 1'b0, NN);
        drain();
        chk32("t6_count", 32'(out_log.size()), 32'd16);
        chk32("t6_out0", out_log[0], 32'd0);
        chk32("t6_out2", out_log[2], 32'd8);
        chk32("t6_out13", out_log[13], 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
